// File: rtl/gpu_reg_sched.sv
// Access scheduler for the 64x32 dual-port GPU register file.
// Shares ports A/B among ALU writeback, operand fetch, load writeback and
// host access, and forwards same-cycle write data into read responses.
//
// Handshake: every requester holds req (with its address/data) steady until
// it sees ack; ack is combinational and means the access is issued on a port
// in this very cycle. op_valid / host_rvalid are one-cycle pulses, and their
// data outputs hold the last delivered value until the next pulse.
module gpu_reg_sched (
  input  logic        sys_clk,
  input  logic        nreset,
  input  logic        alu_we,
  input  logic [5:0]  alu_waddr,
  input  logic [31:0] alu_wdata,
  input  logic        op_req,
  input  logic [5:0]  op_src,
  input  logic [5:0]  op_dst,
  output logic        op_ack,
  output logic        op_valid,
  output logic [31:0] op_sdata,
  output logic [31:0] op_ddata,
  input  logic        mem_req,
  input  logic [5:0]  mem_waddr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [5:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic [5:0]  aa,
  output logic [31:0] da,
  output logic        nwea,
  output logic        clka,
  output logic [5:0]  ab,
  output logic [31:0] db,
  output logic        nweb,
  output logic        clkb,
  input  logic [31:0] qa,
  input  logic [31:0] qb
);

  // SPLIT: the src operand has been read, the dst read is waiting for port A.
  typedef enum logic {S_IDLE = 1'b0, S_SPLIT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_fetch_pend;
  logic        w_src_rd;
  logic        w_dst_rd;
  logic        w_a_busy;
  logic        w_b_busy;
  logic        w_mem_ok;
  logic        w_mem_on_a;
  logic        w_mem_on_b;
  logic        w_mem_go;
  logic        w_host_clash;
  logic        w_host_ok;
  logic        w_host_on_a;
  logic        w_host_on_b;
  logic        w_host_rd;

  logic        w_wa_en;
  logic        w_wb_en;
  logic [32:0] w_src_f;
  logic [32:0] w_dst_f;
  logic [32:0] w_host_f;

  logic        r_src_pend;
  logic        r_src_same;
  logic        r_src_fwd;
  logic [31:0] r_src_fdata;
  logic [31:0] r_hold;
  logic        r_op_valid;
  logic        r_dst_fwd;
  logic [31:0] r_dst_fdata;
  logic [31:0] r_sdata_q;
  logic [31:0] r_ddata_q;
  logic        r_host_valid;
  logic        r_host_on_b;
  logic        r_host_fwd;
  logic [31:0] r_host_fdata;
  logic [31:0] r_host_q;

  logic [31:0] w_src_resp;
  logic [31:0] w_sdata_new;
  logic [31:0] w_ddata_new;
  logic [31:0] w_host_new;

  // Returns {hit, data}: the newest data written this cycle to address ra.
  // Port A's write is preferred when both ports write the same address.
  function automatic logic [32:0] fwd_lookup(
    input logic [5:0]  ra,
    input logic        wa_en,
    input logic [5:0]  wa_addr,
    input logic [31:0] wa_data,
    input logic        wb_en,
    input logic [5:0]  wb_addr,
    input logic [31:0] wb_data
  );
    logic [32:0] res;
    res = '0;
    if (wb_en && (wb_addr == ra)) res = {1'b1, wb_data};
    if (wa_en && (wa_addr == ra)) res = {1'b1, wa_data};
    return res;
  endfunction

  // Fixed-priority claims: ALU and operand fetch own their ports first,
  // then mem and host fill whatever is left, port B preferred, mem first.
  assign w_fetch_pend = nreset & (((r_state == S_IDLE) & op_req) | (r_state == S_SPLIT));
  assign w_src_rd     = nreset & (r_state == S_IDLE) & op_req;
  assign w_dst_rd     = w_fetch_pend & ~alu_we;
  assign w_a_busy     = (nreset & alu_we) | w_dst_rd;
  assign w_b_busy     = w_src_rd;

  // A load to the address the ALU is writing waits: the ALU result is newer.
  assign w_mem_ok     = nreset & mem_req & ~(alu_we & (mem_waddr == alu_waddr));
  assign w_mem_on_b   = w_mem_ok & ~w_b_busy;
  assign w_mem_on_a   = w_mem_ok & w_b_busy & ~w_a_busy;
  assign w_mem_go     = w_mem_on_a | w_mem_on_b;

  // Host writes never race another write to the same address; reads may.
  assign w_host_clash = host_we & ((alu_we & (host_addr == alu_waddr)) |
                                   (w_mem_go & (host_addr == mem_waddr)));
  assign w_host_ok    = nreset & host_req & ~w_host_clash;
  assign w_host_on_b  = w_host_ok & ~w_b_busy & ~w_mem_on_b;
  assign w_host_on_a  = w_host_ok & ~w_host_on_b & ~w_a_busy & ~w_mem_on_a;
  assign w_host_rd    = (w_host_on_a | w_host_on_b) & ~host_we;

  assign op_ack   = w_dst_rd;
  assign mem_ack  = w_mem_go;
  assign host_ack = w_host_on_a | w_host_on_b;

  // Port drive: idle ports are disabled with address/data parked at zero.
  always_comb begin
    aa   = '0;
    da   = '0;
    nwea = 1'b1;
    clka = 1'b0;
    ab   = '0;
    db   = '0;
    nweb = 1'b1;
    clkb = 1'b0;
    if (nreset && alu_we) begin
      aa = alu_waddr; da = alu_wdata; nwea = 1'b0; clka = 1'b1;
    end else if (w_dst_rd) begin
      aa = op_dst; clka = 1'b1;
    end else if (w_mem_on_a) begin
      aa = mem_waddr; da = mem_wdata; nwea = 1'b0; clka = 1'b1;
    end else if (w_host_on_a) begin
      aa = host_addr; da = host_we ? host_wdata : 32'd0; nwea = ~host_we; clka = 1'b1;
    end
    if (w_src_rd) begin
      ab = op_src; clkb = 1'b1;
    end else if (w_mem_on_b) begin
      ab = mem_waddr; db = mem_wdata; nweb = 1'b0; clkb = 1'b1;
    end else if (w_host_on_b) begin
      ab = host_addr; db = host_we ? host_wdata : 32'd0; nweb = ~host_we; clkb = 1'b1;
    end
  end

  assign w_wa_en  = clka & ~nwea;
  assign w_wb_en  = clkb & ~nweb;
  assign w_src_f  = fwd_lookup(op_src,    w_wa_en, aa, da, w_wb_en, ab, db);
  assign w_dst_f  = fwd_lookup(op_dst,    w_wa_en, aa, da, w_wb_en, ab, db);
  assign w_host_f = fwd_lookup(host_addr, w_wa_en, aa, da, w_wb_en, ab, db);

  // Next-state: a fetch that loses port A to the ALU parks in SPLIT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (op_req && alu_we) w_state_nxt = S_SPLIT;
      S_SPLIT: if (!alu_we)          w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Response tracking: remember which reads were issued and whether their
  // data must come from a same-cycle write instead of the RAM output.
  always_ff @(posedge sys_clk) begin
    if (!nreset) begin
      r_src_pend   <= 1'b0;
      r_src_same   <= 1'b0;
      r_src_fwd    <= 1'b0;
      r_src_fdata  <= '0;
      r_hold       <= '0;
      r_op_valid   <= 1'b0;
      r_dst_fwd    <= 1'b0;
      r_dst_fdata  <= '0;
      r_sdata_q    <= '0;
      r_ddata_q    <= '0;
      r_host_valid <= 1'b0;
      r_host_on_b  <= 1'b0;
      r_host_fwd   <= 1'b0;
      r_host_fdata <= '0;
      r_host_q     <= '0;
    end else begin
      r_src_pend   <= w_src_rd;
      r_src_same   <= w_src_rd & w_dst_rd;
      r_src_fwd    <= w_src_f[32];
      r_src_fdata  <= w_src_f[31:0];
      if (r_src_pend) r_hold <= w_src_resp;
      r_op_valid   <= w_dst_rd;
      r_dst_fwd    <= w_dst_f[32];
      r_dst_fdata  <= w_dst_f[31:0];
      if (r_op_valid) begin
        r_sdata_q <= w_sdata_new;
        r_ddata_q <= w_ddata_new;
      end
      r_host_valid <= w_host_rd;
      r_host_on_b  <= w_host_on_b;
      r_host_fwd   <= w_host_f[32];
      r_host_fdata <= w_host_f[31:0];
      if (r_host_valid) r_host_q <= w_host_new;
    end
  end

  // A split fetch takes src from the holding register; an unsplit one
  // takes it straight from this cycle's port B response.
  assign w_src_resp  = r_src_fwd ? r_src_fdata : qb;
  assign w_sdata_new = r_src_same ? w_src_resp : r_hold;
  assign w_ddata_new = r_dst_fwd ? r_dst_fdata : qa;
  assign w_host_new  = r_host_fwd ? r_host_fdata : (r_host_on_b ? qb : qa);

  assign op_valid    = r_op_valid;
  assign op_sdata    = r_op_valid ? w_sdata_new : r_sdata_q;
  assign op_ddata    = r_op_valid ? w_ddata_new : r_ddata_q;
  assign host_rvalid = r_host_valid;
  assign host_rdata  = r_host_valid ? w_host_new : r_host_q;

endmodule

// File: tb/tb_gpu_reg_sched.sv
// Self-checking bench for gpu_reg_sched: directed scenarios, then random
// traffic against an architectural register-file reference model.
module tb_gpu_reg_sched;

  logic        sys_clk;
  logic        nreset;
  logic        alu_we;
  logic [5:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        op_req;
  logic [5:0]  op_src;
  logic [5:0]  op_dst;
  logic        op_ack;
  logic        op_valid;
  logic [31:0] op_sdata;
  logic [31:0] op_ddata;
  logic        mem_req;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        host_req;
  logic        host_we;
  logic [5:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic [5:0]  aa;
  logic [31:0] da;
  logic        nwea;
  logic        clka;
  logic [5:0]  ab;
  logic [31:0] db;
  logic        nweb;
  logic        clkb;
  logic [31:0] qa = '0;
  logic [31:0] qb = '0;

  // Physical register file: read-before-write, so forwarding is visible.
  logic [31:0] ram [64] = '{default: 32'd0};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural register contents plus fetch/port rules.
  logic [31:0] m_rf [64];
  bit          m_split;
  logic [31:0] m_src_cap;
  logic [63:0] op_exp_q[$];
  logic [31:0] host_exp_q[$];
  bit          exp_opv, exp_hv;
  logic [31:0] last_s, last_d, last_h;
  bit          e_op_ack, e_mem_ack, e_host_ack;
  bit          o_op_ack, o_mem_ack, o_host_ack, o_op_valid, o_host_rvalid;
  logic [3:0]  o_ports;

  gpu_reg_sched dut (
    .sys_clk(sys_clk), .nreset(nreset),
    .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .op_req(op_req), .op_src(op_src), .op_dst(op_dst), .op_ack(op_ack),
    .op_valid(op_valid), .op_sdata(op_sdata), .op_ddata(op_ddata),
    .mem_req(mem_req), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .aa(aa), .da(da), .nwea(nwea), .clka(clka),
    .ab(ab), .db(db), .nweb(nweb), .clkb(clkb),
    .qa(qa), .qb(qb)
  );

  // Clock
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // RAM behaviour for both ports.
  always @(posedge sys_clk) begin
    if (clka) begin
      if (!nwea) ram[aa] <= da;
      qa <= ram[aa];
    end
    if (clkb) begin
      if (!nweb) ram[ab] <= db;
      qb <= ram[ab];
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Evaluate one cycle's issue decisions against the model (inputs stable).
  task automatic model_comb();
    int nfree;
    bit src_rd, dst_rd, hclash;
    o_op_ack   = op_ack;
    o_mem_ack  = mem_ack;
    o_host_ack = host_ack;
    o_ports    = {clka, clkb, nwea, nweb};
    if (!nreset) begin
      e_op_ack = 0; e_mem_ack = 0; e_host_ack = 0;
      m_split = 0; exp_opv = 0; exp_hv = 0;
      op_exp_q.delete(); host_exp_q.delete();
      last_s = '0; last_d = '0; last_h = '0;
      check_eq("rst_acks", 32'({op_ack, mem_ack, host_ack}), 32'd0);
      check_eq("rst_ports", 32'({clka, clkb, nwea, nweb}), 32'h3);
      return;
    end
    src_rd = op_req && !m_split;
    dst_rd = (op_req || m_split) && !alu_we;
    nfree  = ((alu_we || dst_rd) ? 0 : 1) + (src_rd ? 0 : 1);
    e_mem_ack = mem_req && !(alu_we && (mem_waddr == alu_waddr)) && (nfree > 0);
    if (e_mem_ack) nfree--;
    hclash = host_we && ((alu_we && (host_addr == alu_waddr)) ||
                         (e_mem_ack && (host_addr == mem_waddr)));
    e_host_ack = host_req && !hclash && (nfree > 0);
    e_op_ack   = dst_rd;
    check_eq("op_ack",   32'(op_ack),   32'(e_op_ack));
    check_eq("mem_ack",  32'(mem_ack),  32'(e_mem_ack));
    check_eq("host_ack", 32'(host_ack), 32'(e_host_ack));
    if (alu_we) begin
      check_eq("alu_port_a", 32'({clka, nwea, aa}), 32'({1'b1, 1'b0, alu_waddr}));
      check_eq("alu_data_a", da, alu_wdata);
    end
    // Architectural effect: writes land, then reads see the newest value.
    if (alu_we)                m_rf[alu_waddr] = alu_wdata;
    if (e_mem_ack)             m_rf[mem_waddr] = mem_wdata;
    if (e_host_ack && host_we) m_rf[host_addr] = host_wdata;
    if (src_rd) m_src_cap = m_rf[op_src];
    exp_opv = dst_rd;
    if (dst_rd) op_exp_q.push_back({m_src_cap, m_rf[op_dst]});
    exp_hv = e_host_ack && !host_we;
    if (exp_hv) host_exp_q.push_back(m_rf[host_addr]);
    m_split = (op_req || m_split) && alu_we;
  endtask

  // Check the registered results one edge later.
  task automatic model_seq_check();
    logic [63:0] e;
    o_op_valid    = op_valid;
    o_host_rvalid = host_rvalid;
    check_eq("op_valid", 32'(op_valid), 32'(exp_opv));
    if (exp_opv && op_exp_q.size() > 0) begin
      e = op_exp_q.pop_front();
      last_s = e[63:32];
      last_d = e[31:0];
    end
    check_eq("op_sdata", op_sdata, last_s);
    check_eq("op_ddata", op_ddata, last_d);
    check_eq("host_rvalid", 32'(host_rvalid), 32'(exp_hv));
    if (exp_hv && host_exp_q.size() > 0) last_h = host_exp_q.pop_front();
    check_eq("host_rdata", host_rdata, last_h);
    exp_opv = 0;
    exp_hv  = 0;
  endtask

  // One clock cycle; entered and left at the falling edge.
  task automatic cycle();
    #1;
    model_comb();
    @(posedge sys_clk);
    #1;
    model_seq_check();
    @(negedge sys_clk);
  endtask

  task automatic idle_inputs();
    alu_we = 0; alu_waddr = '0; alu_wdata = '0;
    op_req = 0; op_src = '0; op_dst = '0;
    mem_req = 0; mem_waddr = '0; mem_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 64; i++) m_rf[i] = '0;
    m_split = 0; m_src_cap = '0; exp_opv = 0; exp_hv = 0;
    last_s = '0; last_d = '0; last_h = '0;
    idle_inputs();
    nreset = 0;
    for (int i = 0; i < 3; i++) cycle();
    nreset = 1;
    cycle();

    // Mem write then unsplit fetch of the same register.
    mem_req = 1; mem_waddr = 6'd5; mem_wdata = 32'h1234_5678;
    cycle();
    check_eq("t1_mem_ack", 32'(o_mem_ack), 32'd1);
    mem_req = 0; op_req = 1; op_src = 6'd5; op_dst = 6'd5;
    cycle();
    check_eq("t1_op_ack", 32'(o_op_ack), 32'd1);
    check_eq("t1_op_valid", 32'(o_op_valid), 32'd1);
    check_eq("t1_sdata", op_sdata, 32'h1234_5678);
    check_eq("t1_ddata", op_ddata, 32'h1234_5678);
    op_req = 0;
    cycle();

    // Fetch split by two ALU write cycles.
    op_req = 1; op_src = 6'd3; op_dst = 6'd4;
    alu_we = 1; alu_waddr = 6'd4; alu_wdata = 32'hAAAA_0001;
    cycle();
    check_eq("t2_wait0", 32'(o_op_ack), 32'd0);
    cycle();
    check_eq("t2_wait1", 32'(o_op_ack), 32'd0);
    alu_we = 0;
    cycle();
    check_eq("t2_ack", 32'(o_op_ack), 32'd1);
    check_eq("t2_valid", 32'(o_op_valid), 32'd1);
    check_eq("t2_ddata", op_ddata, 32'hAAAA_0001);
    op_req = 0;
    cycle();

    // Forwarding of a same-cycle ALU write into the src read.
    op_req = 1; op_src = 6'd7; op_dst = 6'd8;
    alu_we = 1; alu_waddr = 6'd7; alu_wdata = 32'hDEAD_BEEF;
    cycle();
    alu_we = 0;
    cycle();
    check_eq("t3_ack", 32'(o_op_ack), 32'd1);
    check_eq("t3_sdata", op_sdata, 32'hDEAD_BEEF);
    op_req = 0;
    cycle();

    // Back-to-back fetches saturate both ports; mem and host wait.
    op_req = 1; mem_req = 1; mem_waddr = 6'd20; mem_wdata = 32'h0BAD_F00D;
    host_req = 1; host_we = 0; host_addr = 6'd5;
    for (int i = 0; i < 3; i++) begin
      op_src = 6'(i + 10); op_dst = 6'(i + 11);
      cycle();
      check_eq("t4_mem_wait", 32'(o_mem_ack), 32'd0);
      check_eq("t4_host_wait", 32'(o_host_ack), 32'd0);
    end
    op_req = 0;
    cycle();
    check_eq("t4_mem_go", 32'(o_mem_ack), 32'd1);
    check_eq("t4_host_go", 32'(o_host_ack), 32'd1);
    check_eq("t4_host_rvalid", 32'(o_host_rvalid), 32'd1);
    check_eq("t4_host_rdata", host_rdata, 32'h1234_5678);
    mem_req = 0; host_req = 0;
    cycle();

    // Only port B frees in SPLIT: mem goes first, host after.
    op_req = 1; op_src = 6'd1; op_dst = 6'd2;
    alu_we = 1; alu_waddr = 6'd30; alu_wdata = 32'h3030_3030;
    mem_req = 1; mem_waddr = 6'd21; mem_wdata = 32'h2121_2121;
    host_req = 1; host_we = 0; host_addr = 6'd20;
    cycle();
    check_eq("t4b_mem_wait", 32'(o_mem_ack), 32'd0);
    cycle();
    check_eq("t4b_mem_first", 32'(o_mem_ack), 32'd1);
    check_eq("t4b_host_wait", 32'(o_host_ack), 32'd0);
    mem_req = 0; alu_we = 0;
    cycle();
    check_eq("t4b_op_ack", 32'(o_op_ack), 32'd1);
    check_eq("t4b_host_go", 32'(o_host_ack), 32'd1);
    check_eq("t4b_host_rdata", host_rdata, 32'h0BAD_F00D);
    op_req = 0; host_req = 0;
    cycle();

    // Mem write to the address the ALU writes is deferred one cycle.
    alu_we = 1; alu_waddr = 6'd9; alu_wdata = 32'h1111_0009;
    mem_req = 1; mem_waddr = 6'd9; mem_wdata = 32'h2222_0009;
    cycle();
    check_eq("t5_deferred", 32'(o_mem_ack), 32'd0);
    alu_we = 0;
    cycle();
    check_eq("t5_mem_ack", 32'(o_mem_ack), 32'd1);
    mem_req = 0;
    cycle();
    check_eq("t5_r9", ram[9], 32'h2222_0009);

    // Reset in SPLIT abandons the fetch.
    op_req = 1; op_src = 6'd1; op_dst = 6'd2;
    alu_we = 1; alu_waddr = 6'd31; alu_wdata = 32'h3131_3131;
    cycle();
    idle_inputs();
    nreset = 0;
    cycle();
    check_eq("t6_rst_ack", 32'(o_op_ack), 32'd0);
    check_eq("t6_rst_ports", 32'(o_ports), 32'h3);
    check_eq("t6_rst_valid", 32'(o_op_valid), 32'd0);
    cycle();
    nreset = 1;
    cycle();
    check_eq("t6_no_valid", 32'(o_op_valid), 32'd0);
    check_eq("t6_no_ack", 32'(o_op_ack), 32'd0);
    op_req = 1; op_src = 6'd1; op_dst = 6'd2;
    cycle();
    check_eq("t6_idle_ack", 32'(o_op_ack), 32'd1);
    op_req = 0;
    cycle();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      alu_we    = ($urandom_range(0, 99) < 40);
      alu_waddr = 6'($urandom_range(0, 15));
      alu_wdata = $urandom;
      if (!op_req && $urandom_range(0, 1) == 1) begin
        op_req = 1;
        op_src = 6'($urandom_range(0, 15));
        op_dst = 6'($urandom_range(0, 15));
      end
      if (!mem_req && $urandom_range(0, 2) == 0) begin
        mem_req   = 1;
        mem_waddr = 6'($urandom_range(0, 15));
        mem_wdata = $urandom;
      end
      if (!host_req && $urandom_range(0, 2) == 0) begin
        host_req   = 1;
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 6'($urandom_range(0, 15));
        host_wdata = $urandom;
      end
      cycle();
      if (e_op_ack)   op_req   = 0;
      if (e_mem_ack)  mem_req  = 0;
      if (e_host_ack) host_req = 0;
    end

    // Drain outstanding requests, then compare the whole register file.
    alu_we = 0;
    guard = 0;
    while ((op_req || mem_req || host_req) && guard < 50) begin
      cycle();
      if (e_op_ack)   op_req   = 0;
      if (e_mem_ack)  mem_req  = 0;
      if (e_host_ack) host_req = 0;
      guard++;
    end
    check_eq("drain_done", 32'({op_req, mem_req, host_req}), 32'd0);
    idle_inputs();
    cycle();
    for (int i = 0; i < 64; i++) check_eq("final_rf", ram[i], m_rf[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
